// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes, bubbles and redirects a 5-stage pipeline
// on data-memory misses, taken branches/jumps, fetch misses and load-use hazards.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dRENMEM,
  input  logic        dWENMEM,
  input  logic        haltMEM,
  input  logic        jmpMEM,
  input  logic        jmprMEM,
  input  logic        b_eqMEM,
  input  logic        b_neMEM,
  input  logic        zeroMEM,
  input  logic        memtoregEX,
  input  logic [4:0]  rdEX,
  input  logic [4:0]  rsID,
  input  logic [4:0]  rtID,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DWAIT = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall;
  logic redirect;
  logic load_use;

  assign mem_stall = (dRENMEM | dWENMEM) & ~dhit;
  assign redirect  = jmpMEM | jmprMEM | (b_eqMEM & zeroMEM) | (b_neMEM & ~zeroMEM);
  assign load_use  = memtoregEX & (rdEX != 5'd0) & ((rdEX == rsID) | (rdEX == rtID));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = S_RUN;
    unique case (state_q)
      S_RUN: begin
        if (mem_stall)    state_d = S_DWAIT;
        else if (haltMEM) state_d = S_HALT;
        else              state_d = S_RUN;
      end
      S_DWAIT: state_d = dhit ? S_RUN : S_DWAIT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase

    halt_d = (state_d == S_HALT);

    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (state_q != S_HALT) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Reset and HALT both force everything quiet; otherwise fixed priority.
  always_comb begin
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (RST || state_q == S_HALT || mem_stall) begin
      pc_en = 1'b0;
    end else if (redirect) begin
      pc_en       = 1'b1;
      pc_sel      = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (!ihit) begin
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (load_use) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a behavioural model predicts each cycle's
// outputs at drive time; predictions are popped and compared after settling.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, dRENMEM, dWENMEM, haltMEM, jmpMEM, jmprMEM;
  logic        b_eqMEM, b_neMEM, zeroMEM, memtoregEX;
  logic [4:0]  rdEX, rsID, rtID;
  logic        pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, halt;
  logic [15:0] stall_cnt;

  always #5 CLK = ~CLK;

  hazard_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dRENMEM(dRENMEM), .dWENMEM(dWENMEM), .haltMEM(haltMEM),
    .jmpMEM(jmpMEM), .jmprMEM(jmprMEM), .b_eqMEM(b_eqMEM), .b_neMEM(b_neMEM),
    .zeroMEM(zeroMEM), .memtoregEX(memtoregEX),
    .rdEX(rdEX), .rsID(rsID), .rtID(rtID),
    .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halt(halt),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic       rst, ihit, dhit, dren, dwen, hlt, jmp, jmpr, beq, bne, zero, mtr;
    logic [4:0] rdex, rsid, rtid;
  } stim_t;

  typedef struct {
    string       tag;
    logic [8:0]  ctrl;
    logic        halt;
    logic [15:0] cnt;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: 0 RUN, 1 DWAIT, 2 HALT
  logic [1:0]  m_st   = 2'd0;
  logic        m_halt = 1'b0;
  logic [15:0] m_cnt  = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {pc_en,pc_sel,ifid_en,idex_en,exmem_en,memwb_en,ifid_fl,idex_fl,exmem_fl}
  function automatic logic [8:0] model_ctrl(input stim_t s, input logic [1:0] st);
    logic miss, taken, lu;
    miss  = (s.dren | s.dwen) & ~s.dhit;
    taken = s.jmp | s.jmpr | (s.beq & s.zero) | (s.bne & ~s.zero);
    lu    = s.mtr && (s.rdex != 0) && ((s.rdex == s.rsid) || (s.rdex == s.rtid));
    if (s.rst || st == 2'd2 || miss) return 9'b0_0_0000_000;
    if (taken)                       return 9'b1_1_1111_111;
    if (!s.ihit)                     return 9'b0_0_1111_100;
    if (lu)                          return 9'b0_0_0111_010;
    return 9'b1_0_1111_000;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, ihit: 1'b1, dhit: 1'b0, dren: 1'b0, dwen: 1'b0, hlt: 1'b0,
          jmp: 1'b0, jmpr: 1'b0, beq: 1'b0, bne: 1'b0, zero: 1'b0, mtr: 1'b0,
          rdex: 5'd0, rsid: 5'd0, rtid: 5'd0};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    RST = s.rst; ihit = s.ihit; dhit = s.dhit; dRENMEM = s.dren; dWENMEM = s.dwen;
    haltMEM = s.hlt; jmpMEM = s.jmp; jmprMEM = s.jmpr; b_eqMEM = s.beq;
    b_neMEM = s.bne; zeroMEM = s.zero; memtoregEX = s.mtr;
    rdEX = s.rdex; rsID = s.rsid; rtID = s.rtid;
  endtask

  // One clock cycle: drive, predict, compare, clock, advance model.
  task automatic cycle(input stim_t s, input string tag);
    exp_t e, got;
    logic [8:0] c;
    logic miss;
    apply(s);
    c = model_ctrl(s, m_st);
    e = '{tag: tag, ctrl: c, halt: m_halt, cnt: m_cnt, st: m_st};
    exp_q.push_back(e);
    #2;
    got = exp_q.pop_front();
    check({got.tag, ".ctrl"}, 32'({pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
                                   ifid_flush, idex_flush, exmem_flush}), 32'(got.ctrl));
    check({got.tag, ".halt"}, 32'(halt), 32'(got.halt));
    check({got.tag, ".cnt"},  32'(stall_cnt), 32'(got.cnt));
    check({got.tag, ".state"}, 32'(dut.state_q), 32'(got.st));
    @(posedge CLK);
    miss = (s.dren | s.dwen) & ~s.dhit;
    if (s.rst) begin
      m_st = 2'd0; m_halt = 1'b0; m_cnt = 16'd0;
    end else begin
      if (!c[8] && m_st != 2'd2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      case (m_st)
        2'd0:    m_st = miss ? 2'd1 : (s.hlt ? 2'd2 : 2'd0);
        2'd1:    m_st = s.dhit ? 2'd0 : 2'd1;
        default: m_st = 2'd2;
      endcase
      m_halt = (m_st == 2'd2);
    end
    #1;
  endtask

  initial begin
    stim_t s;
    apply(idle());
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Reset held: everything quiet.
    s = idle(); s.rst = 1'b1;
    cycle(s, "reset0");
    cycle(s, "reset1");

    // Normal flow, no hazard even though registers match (not a load).
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.rdex = 5'd8; s.rsid = 5'd8; s.rtid = 5'(i);
      cycle(s, "normal");
    end

    // Load-use via rs, via rt, and rdEX=0 never stalls.
    s = idle(); s.mtr = 1'b1; s.rdex = 5'd8; s.rsid = 5'd8; s.rtid = 5'd3;
    cycle(s, "lu_rs");
    s.rsid = 5'd2; s.rtid = 5'd8;
    cycle(s, "lu_rt");
    s.rdex = 5'd0; s.rsid = 5'd0; s.rtid = 5'd0;
    cycle(s, "lu_r0");
    s.rdex = 5'd9; s.rsid = 5'd8; s.rtid = 5'd10;
    cycle(s, "lu_nomatch");

    // Data miss for three cycles, then hit.
    s = idle(); s.dren = 1'b1;
    for (int i = 0; i < 3; i++) cycle(s, "dmiss");
    s.dhit = 1'b1;
    cycle(s, "dmiss_hit");
    s = idle(); s.dwen = 1'b1;
    cycle(s, "wmiss");
    s.dhit = 1'b1;
    cycle(s, "wmiss_hit");
    cycle(idle(), "after_miss");

    // Redirect beats ~ihit and load_use; every redirect source.
    s = idle(); s.bne = 1'b1; s.ihit = 1'b0; s.mtr = 1'b1; s.rdex = 5'd4; s.rsid = 5'd4;
    cycle(s, "bne_taken");
    s = idle(); s.bne = 1'b1; s.zero = 1'b1;
    cycle(s, "bne_nottaken");
    s = idle(); s.beq = 1'b1; s.zero = 1'b1;
    cycle(s, "beq_taken");
    s = idle(); s.beq = 1'b1;
    cycle(s, "beq_nottaken");
    s = idle(); s.jmp = 1'b1;
    cycle(s, "jmp");
    s = idle(); s.jmpr = 1'b1;
    cycle(s, "jmpr");
    s = idle(); s.jmp = 1'b1; s.dren = 1'b1;
    cycle(s, "jmp_under_miss");
    s.dhit = 1'b1;
    cycle(s, "jmp_after_hit");

    // Fetch miss outranks load_use.
    s = idle(); s.ihit = 1'b0; s.mtr = 1'b1; s.rdex = 5'd7; s.rtid = 5'd7;
    cycle(s, "imiss_lu");
    s = idle(); s.ihit = 1'b0;
    cycle(s, "imiss");

    // Reset while waiting on data.
    s = idle(); s.dren = 1'b1;
    cycle(s, "dwait_a");
    cycle(s, "dwait_b");
    s.rst = 1'b1;
    cycle(s, "dwait_rst");
    cycle(idle(), "post_dwait_rst");

    // Halt: last transfer, then sticky quiet until reset.
    s = idle(); s.hlt = 1'b1;
    cycle(s, "halt_edge");
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.ihit = (i != 1);
      cycle(s, "halted");
    end
    s = idle(); s.rst = 1'b1;
    cycle(s, "halt_rst");
    cycle(idle(), "post_halt_rst");

    // Constrained-random mix.
    for (int i = 0; i < 400; i++) begin
      s.rst  = ($urandom_range(0, 24) == 0);
      s.ihit = ($urandom_range(0, 3) != 0);
      s.dhit = $urandom_range(0, 1);
      s.dren = ($urandom_range(0, 3) == 0);
      s.dwen = ($urandom_range(0, 5) == 0);
      s.hlt  = ($urandom_range(0, 29) == 0);
      s.jmp  = ($urandom_range(0, 9) == 0);
      s.jmpr = ($urandom_range(0, 9) == 0);
      s.beq  = ($urandom_range(0, 7) == 0);
      s.bne  = ($urandom_range(0, 7) == 0);
      s.zero = $urandom_range(0, 1);
      s.mtr  = $urandom_range(0, 1);
      s.rdex = 5'($urandom_range(0, 5));
      s.rsid = 5'($urandom_range(0, 5));
      s.rtid = 5'($urandom_range(0, 5));
      cycle(s, "rand");
    end

    // Saturation, then one reset cycle.
    s = idle(); s.rst = 1'b1;
    cycle(s, "sat_rst0");
    s = idle(); s.ihit = 1'b0;
    for (int i = 0; i < 65540; i++) cycle(s, "sat");
    cycle(s, "sat_hold");
    check("sat_value", 32'(stall_cnt), 32'h0000_FFFF);
    s.rst = 1'b1;
    cycle(s, "sat_rst");
    cycle(idle(), "post_sat_rst");

    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
